// File: rtl/replica_pkg.sv
// Shared types for the replica datapath: total-distance word, run-request width
// and the run_sequencer state encoding.
package replica_pkg;

   localparam int TOTAL_W     = 32;
   localparam int RUN_TIMES_W = 24;

   typedef logic [TOTAL_W-1:0] total_data_t;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_ISSUE      = 3'd1,
      ST_WAIT_START = 3'd2,
      ST_WAIT_END   = 3'd3,
      ST_SCAN       = 3'd4,
      ST_DONE       = 3'd5
   } run_seq_state_t;

endpackage

// File: rtl/run_req_fifo.sv
// Small request FIFO with occupancy output; ready depends only on the current
// count, so a full FIFO refuses a push even in a cycle where it pops.
module run_req_fifo #(
   parameter int depth = 4,
   parameter int width = 24
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [width-1:0]         wdata,
   input  logic                     pop,
   output logic [width-1:0]         rdata,
   output logic                     ready,
   output logic [$clog2(depth):0]   count
);

   localparam int PTR_W = $clog2(depth);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(depth);

   logic [width-1:0] mem_r [depth];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign ready     = (count < FULL_COUNT);
   assign do_push_s = push & ready;
   assign do_pop_s  = pop & (count != {(PTR_W+1){1'b0}});
   assign rdata     = mem_r[rd_ptr_r];

   // Storage is not reset; only occupied slots are ever read.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count    <= {(PTR_W+1){1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/run_sequencer.sv
// Batch scheduler: issues queued runs to node_control, then rotates the whole
// total-distance chain once and reports its minimum and position.
module run_sequencer
   import replica_pkg::*;
#(
   parameter int replica_num = 32,
   parameter int qdepth      = 4
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic [RUN_TIMES_W-1:0]            req_times,
   output logic                              run_write,
   output logic [RUN_TIMES_W-1:0]            run_times,
   input  logic                              running,
   input  logic                              bus_dist_req,
   output logic                              scan_active,
   output logic                              distance_shift,
   output total_data_t                       distance_wdata,
   input  total_data_t                       distance_rdata,
   output logic                              best_valid,
   output total_data_t                       best_dist,
   output logic [$clog2(2*replica_num)-1:0]  best_idx,
   output logic                              batch_done,
   output logic [$clog2(qdepth):0]           queue_count
);

   localparam int CHAIN_LEN = 2 * replica_num;
   localparam int IDX_W     = $clog2(CHAIN_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHAIN_LEN - 1);

   run_seq_state_t         state_r;
   logic [IDX_W-1:0]       shift_cnt_r;
   logic [RUN_TIMES_W-1:0] head_s;
   logic                   pop_s;

   // The host only gets the chain back between batches.
   assign pop_s          = (state_r == ST_IDLE) && (queue_count != '0) && !bus_dist_req;
   assign scan_active    = (state_r == ST_SCAN);
   assign distance_wdata = distance_rdata;

   run_req_fifo #(
      .depth (qdepth),
      .width (RUN_TIMES_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (req_valid),
      .wdata   (req_times),
      .pop     (pop_s),
      .rdata   (head_s),
      .ready   (req_ready),
      .count   (queue_count)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r        <= ST_IDLE;
         shift_cnt_r    <= {IDX_W{1'b0}};
         run_write      <= 1'b0;
         run_times      <= {RUN_TIMES_W{1'b0}};
         distance_shift <= 1'b0;
         best_valid     <= 1'b0;
         best_dist      <= '0;
         best_idx       <= {IDX_W{1'b0}};
         batch_done     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               batch_done <= 1'b0;
               run_write  <= 1'b0;
               if (pop_s) begin
                  best_valid  <= 1'b0;
                  shift_cnt_r <= {IDX_W{1'b0}};
                  if (head_s != {RUN_TIMES_W{1'b0}}) begin
                     run_write <= 1'b1;
                     run_times <= head_s;
                     state_r   <= ST_ISSUE;
                  end else begin
                     distance_shift <= 1'b1;
                     state_r        <= ST_SCAN;
                  end
               end
            end
            ST_ISSUE: begin
               run_write <= 1'b0;
               state_r   <= ST_WAIT_START;
            end
            ST_WAIT_START: begin
               if (running) begin
                  state_r <= ST_WAIT_END;
               end
            end
            ST_WAIT_END: begin
               if (!running) begin
                  distance_shift <= 1'b1;
                  shift_cnt_r    <= {IDX_W{1'b0}};
                  state_r        <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               // Strict less-than so ties keep the earliest index.
               if ((shift_cnt_r == {IDX_W{1'b0}}) || (distance_rdata < best_dist)) begin
                  best_dist <= distance_rdata;
                  best_idx  <= shift_cnt_r;
               end
               if (shift_cnt_r == LAST_IDX) begin
                  distance_shift <= 1'b0;
                  best_valid     <= 1'b1;
                  batch_done     <= 1'b1;
                  state_r        <= ST_DONE;
               end else begin
                  shift_cnt_r <= shift_cnt_r + IDX_W'(1);
               end
            end
            ST_DONE: begin
               batch_done <= 1'b0;
               state_r    <= ST_IDLE;
            end
            default: begin
               run_write      <= 1'b0;
               distance_shift <= 1'b0;
               batch_done     <= 1'b0;
               state_r        <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
